// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencer for the 5-stage core: RAW hazard stall, branch flush and
// memory-wait stall, merged into freeze/bubble/flush controls by fixed priority.
//
// state    | meaning
// RUN      | normal flow; a new mem_req is accepted here
// MEM_BUSY | MEM access in progress; whole pipe held (stall_all)
// MEM_DONE | access completes; instruction leaves MEM, mem_req ignored
module hazard_stall_ctrl #(
    parameter int MEM_WAIT   = 2,
    parameter int FORWARD_EN = 0,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       id_src1,
    input  logic [3:0]       id_src2,
    input  logic             id_use_src1,
    input  logic             id_use_src2,
    input  logic             exe_wb_en,
    input  logic [3:0]       exe_dest,
    input  logic             exe_mem_read,
    input  logic             mem_wb_en,
    input  logic [3:0]       mem_dest,
    input  logic             mem_req,
    input  logic             exe_branch,
    output logic             freeze_front,
    output logic             bubble_id,
    output logic             flush,
    output logic             stall_all,
    output logic             branch_taken,
    output logic             mem_busy,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic [1:0] {RUN, MEM_BUSY, MEM_DONE} state_t;

    localparam int WAIT_W = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'((MEM_WAIT > 0) ? MEM_WAIT - 1 : 0);

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              haz;
    logic              src1_exe, src2_exe, src1_mem, src2_mem;

    always_comb begin
        src1_exe = id_use_src1 & (exe_dest == id_src1);
        src2_exe = id_use_src2 & (exe_dest == id_src2);
        src1_mem = id_use_src1 & (mem_dest == id_src1);
        src2_mem = id_use_src2 & (mem_dest == id_src2);
        // With forwarding, only a load in EXE cannot be bypassed in time.
        if (FORWARD_EN != 0)
            haz = exe_mem_read & exe_wb_en & (src1_exe | src2_exe);
        else
            haz = (exe_wb_en & (src1_exe | src2_exe)) | (mem_wb_en & (src1_mem | src2_mem));
    end

    assign stall_all = (state == MEM_BUSY);
    assign mem_busy  = (state == MEM_BUSY);

    // A branch seen under stall_all stays in the held EXE stage and is taken later.
    always_comb begin
        freeze_front = 1'b0;
        bubble_id    = 1'b0;
        flush        = 1'b0;
        branch_taken = 1'b0;
        if (stall_all) begin
            flush = 1'b0;
        end else if (exe_branch) begin
            flush        = 1'b1;
            branch_taken = 1'b1;
        end else if (haz) begin
            freeze_front = 1'b1;
            bubble_id    = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (mem_req && (MEM_WAIT > 0)) begin
                        state    <= MEM_BUSY;
                        wait_cnt <= WAIT_LOAD;
                    end
                end
                MEM_BUSY: begin
                    if (wait_cnt == '0)
                        state <= MEM_DONE;
                    else
                        wait_cnt <= wait_cnt - WAIT_W'(1);
                end
                MEM_DONE: state <= RUN;
                default:  state <= RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cycles <= '0;
        else if ((bubble_id | stall_all) && (stall_cycles != {CNT_W{1'b1}}))
            stall_cycles <= stall_cycles + CNT_W'(1);
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: three parameter variants share one
// stimulus stream; a reference model predicts every cycle's outputs.
module tb_hazard_stall_ctrl;

    typedef struct packed {
        logic       rst;
        logic [3:0] s1, s2;
        logic       u1, u2, ewb;
        logic [3:0] ed;
        logic       emr, mwb;
        logic [3:0] md;
        logic       mreq, br;
    } stim_t;

    typedef struct packed {
        logic ff, bub, fl, sa, bt, mb;
        logic [15:0] cnt;
    } exp_t;
    typedef exp_t [2:0] exp3_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [3:0] id_src1 = '0, id_src2 = '0, exe_dest = '0, mem_dest = '0;
    logic id_use_src1 = 0, id_use_src2 = 0, exe_wb_en = 0, exe_mem_read = 0;
    logic mem_wb_en = 0, mem_req = 0, exe_branch = 0;

    logic [2:0] ff, bub, fl, sa, bt, mb;
    logic [4:0]  cnt0;
    logic [3:0]  cnt1;
    logic [15:0] cnt2;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.MEM_WAIT(2), .FORWARD_EN(0), .CNT_W(5)) u_dut0 (
        .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2),
        .id_use_src1(id_use_src1), .id_use_src2(id_use_src2), .exe_wb_en(exe_wb_en),
        .exe_dest(exe_dest), .exe_mem_read(exe_mem_read), .mem_wb_en(mem_wb_en),
        .mem_dest(mem_dest), .mem_req(mem_req), .exe_branch(exe_branch),
        .freeze_front(ff[0]), .bubble_id(bub[0]), .flush(fl[0]), .stall_all(sa[0]),
        .branch_taken(bt[0]), .mem_busy(mb[0]), .stall_cycles(cnt0));

    hazard_stall_ctrl #(.MEM_WAIT(3), .FORWARD_EN(1), .CNT_W(4)) u_dut1 (
        .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2),
        .id_use_src1(id_use_src1), .id_use_src2(id_use_src2), .exe_wb_en(exe_wb_en),
        .exe_dest(exe_dest), .exe_mem_read(exe_mem_read), .mem_wb_en(mem_wb_en),
        .mem_dest(mem_dest), .mem_req(mem_req), .exe_branch(exe_branch),
        .freeze_front(ff[1]), .bubble_id(bub[1]), .flush(fl[1]), .stall_all(sa[1]),
        .branch_taken(bt[1]), .mem_busy(mb[1]), .stall_cycles(cnt1));

    hazard_stall_ctrl #(.MEM_WAIT(0), .FORWARD_EN(0), .CNT_W(16)) u_dut2 (
        .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2),
        .id_use_src1(id_use_src1), .id_use_src2(id_use_src2), .exe_wb_en(exe_wb_en),
        .exe_dest(exe_dest), .exe_mem_read(exe_mem_read), .mem_wb_en(mem_wb_en),
        .mem_dest(mem_dest), .mem_req(mem_req), .exe_branch(exe_branch),
        .freeze_front(ff[2]), .bubble_id(bub[2]), .flush(fl[2]), .stall_all(sa[2]),
        .branch_taken(bt[2]), .mem_busy(mb[2]), .stall_cycles(cnt2));

    // Reference model: per variant, cycles of stall still owed, a one-cycle
    // "access finishing" flag, and the statistics count.
    int mw_p[3] = '{2, 3, 0};
    int fw_p[3] = '{0, 1, 0};
    int cw_p[3] = '{5, 4, 16};
    int busy_left[3] = '{0, 0, 0};
    bit finishing[3] = '{0, 0, 0};
    int cnt_m[3]     = '{0, 0, 0};

    exp3_t sb[$];
    int checks = 0;
    int passes = 0;
    int cyc    = 0;

    function automatic bit raw_hazard(int fw, stim_t v);
        bit e1, e2, m1, m2;
        e1 = v.u1 && (v.ed == v.s1);
        e2 = v.u2 && (v.ed == v.s2);
        m1 = v.u1 && (v.md == v.s1);
        m2 = v.u2 && (v.md == v.s2);
        if (fw != 0) return v.emr && v.ewb && (e1 || e2);
        return (v.ewb && (e1 || e2)) || (v.mwb && (m1 || m2));
    endfunction

    task automatic drive(input stim_t v);
        exp3_t e;
        @(posedge clk);
        #1;
        rst = v.rst; id_src1 = v.s1; id_src2 = v.s2;
        id_use_src1 = v.u1; id_use_src2 = v.u2; exe_wb_en = v.ewb;
        exe_dest = v.ed; exe_mem_read = v.emr; mem_wb_en = v.mwb;
        mem_dest = v.md; mem_req = v.mreq; exe_branch = v.br;
        for (int d = 0; d < 3; d++) begin
            if (v.rst) begin
                busy_left[d] = 0;
                finishing[d] = 0;
                cnt_m[d]     = 0;
            end
            e[d] = '0;
            e[d].sa  = (busy_left[d] > 0);
            e[d].mb  = e[d].sa;
            e[d].cnt = 16'(cnt_m[d]);
            if (!e[d].sa) begin
                if (v.br) begin
                    e[d].fl = 1'b1;
                    e[d].bt = 1'b1;
                end else if (raw_hazard(fw_p[d], v)) begin
                    e[d].ff  = 1'b1;
                    e[d].bub = 1'b1;
                end
            end
        end
        sb.push_back(e);
        for (int d = 0; d < 3; d++) begin
            if (!v.rst) begin
                if ((e[d].bub || e[d].sa) && cnt_m[d] < (1 << cw_p[d]) - 1)
                    cnt_m[d]++;
                if (busy_left[d] > 0) begin
                    busy_left[d]--;
                    if (busy_left[d] == 0) finishing[d] = 1;
                end else if (finishing[d]) begin
                    finishing[d] = 0;
                end else if (v.mreq && mw_p[d] > 0) begin
                    busy_left[d] = mw_p[d];
                end
            end
        end
    endtask

    always @(negedge clk) begin
        exp3_t e, a;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            a[0] = {ff[0], bub[0], fl[0], sa[0], bt[0], mb[0], 11'b0, cnt0};
            a[1] = {ff[1], bub[1], fl[1], sa[1], bt[1], mb[1], 12'b0, cnt1};
            a[2] = {ff[2], bub[2], fl[2], sa[2], bt[2], mb[2], cnt2};
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (a[d] === e[d]) passes++;
                else
                    $display("FAIL dut%0d cycle %0d: actual ff,bub,fl,sa,bt,mb=%b%b%b%b%b%b cnt=%0d, required %b%b%b%b%b%b cnt=%0d",
                             d, cyc, a[d].ff, a[d].bub, a[d].fl, a[d].sa, a[d].bt, a[d].mb, a[d].cnt,
                             e[d].ff, e[d].bub, e[d].fl, e[d].sa, e[d].bt, e[d].mb, e[d].cnt);
            end
        end
        cyc++;
    end

    initial begin
        stim_t v;
        v = '0; v.rst = 1'b1;
        drive(v); drive(v);
        v = '0;
        drive(v);
        // RAW from EXE, then from MEM, then clear
        v.ewb = 1; v.ed = 4'd3; v.s1 = 4'd3; v.u1 = 1; drive(v);
        v.ewb = 0; v.mwb = 1; v.md = 4'd3; drive(v);
        v = '0; drive(v);
        // ALU result vs load in EXE
        v.ewb = 1; v.ed = 4'd5; v.s2 = 4'd5; v.u2 = 1; drive(v);
        v.emr = 1; drive(v);
        v = '0; drive(v);
        // memory pulse, then mem_req held through the done cycle
        v.mreq = 1; drive(v);
        v.mreq = 0; repeat (5) drive(v);
        v.mreq = 1; repeat (8) drive(v);
        v = '0; drive(v);
        // branch held in EXE across a memory stall
        v.mreq = 1; drive(v);
        v.mreq = 0; v.br = 1; repeat (4) drive(v);
        v.br = 0; repeat (3) drive(v);
        // branch with concurrent load-use hazard
        v.br = 1; v.ewb = 1; v.emr = 1; v.ed = 4'd7; v.s1 = 4'd7; v.u1 = 1; drive(v);
        v = '0; drive(v);
        // reset in the middle of a memory stall
        v.mreq = 1; drive(v);
        v.mreq = 0; drive(v);
        v.rst = 1; drive(v);
        v.rst = 0; repeat (4) drive(v);
        // long load-use run drives the narrow counters into saturation
        v.ewb = 1; v.emr = 1; v.ed = 4'd2; v.s1 = 4'd2; v.u1 = 1; repeat (40) drive(v);
        v = '0; drive(v);
        for (int i = 0; i < 1500; i++) begin
            v.rst  = ($urandom_range(0, 99) == 0);
            v.s1   = 4'($urandom_range(0, 3));
            v.s2   = 4'($urandom_range(0, 3));
            v.ed   = 4'($urandom_range(0, 3));
            v.md   = 4'($urandom_range(0, 3));
            v.u1   = 1'($urandom_range(0, 1));
            v.u2   = 1'($urandom_range(0, 1));
            v.ewb  = 1'($urandom_range(0, 1));
            v.emr  = 1'($urandom_range(0, 1));
            v.mwb  = 1'($urandom_range(0, 1));
            v.mreq = ($urandom_range(0, 5) == 0);
            v.br   = ($urandom_range(0, 4) == 0);
            drive(v);
        end
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        checks++;
        if (sb.size() == 0) passes++;
        else $display("FAIL drain: actual %0d entries left, required 0", sb.size());
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
